serial_magnitude_comparator: RTL

// Bit-serial N-bit magnitude comparator. It accepts two operands through a

---
 rtl/serial_magnitude_comparator.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial N-bit magnitude comparator: walks two captured operands MSB-first,
// one bit per cycle, and returns a single gt/eq/lt result over a valid/ready handshake.
module serial_magnitude_comparator #(
  parameter int DATA_WIDTH = 8,
  parameter int SIGNED     = 0,
  parameter int EARLY_EXIT = 1,
  localparam int CW        = $clog2(DATA_WIDTH + 1),
  localparam int IW        = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  a_gt_b,
  output logic                  a_eq_b,
  output logic                  a_lt_b,
  output logic                  busy,
  output logic [CW-1:0]         cycles
);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  localparam logic [IW-1:0] IDX_MSB = IW'(DATA_WIDTH - 1);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         steps;
  logic                  found, gt_w, lt_w;

  logic start_fire, step_go, last_step;
  logic bit_a, bit_b, diff, cell_gt, cell_lt;
  logic found_next, gt_next, lt_next;
  logic [CW-1:0] steps_inc;

  // Ready is gated by rst_n so it reads 0 for the whole time reset is held.
  assign start_ready  = rst_n & enable & (state == IDLE);
  assign start_fire   = start_valid & start_ready;
  assign step_go      = (state == COMPARE) & enable;
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign steps_inc    = steps + CW'(1);

  // One 1-bit comparator cell evaluated on the current bit; the sign bit swaps gt/lt.
  always_comb begin
    bit_a      = a_q[idx];
    bit_b      = b_q[idx];
    diff       = bit_a ^ bit_b;
    cell_gt    = bit_a & ~bit_b;
    cell_lt    = ~bit_a & bit_b;
    if ((SIGNED != 0) && (idx == IDX_MSB)) begin
      cell_gt = ~bit_a & bit_b;
      cell_lt = bit_a & ~bit_b;
    end
    found_next = found | diff;
    gt_next    = found ? gt_w : cell_gt;
    lt_next    = found ? lt_w : cell_lt;
    last_step  = (idx == '0) || ((EARLY_EXIT != 0) && diff);
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_fire)             state_next = COMPARE;
      COMPARE: if (step_go && last_step)   state_next = DONE;
      DONE:    if (result_ready)           state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // NOTE: operand registers carry no reset; they are only read after a start handshake loads them.
  always_ff @(posedge clk) begin
    if (start_fire) begin
      a_q <= data_a;
      b_q <= data_b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= IDX_MSB;
      steps  <= '0;
      found  <= 1'b0;
      gt_w   <= 1'b0;
      lt_w   <= 1'b0;
      a_gt_b <= 1'b0;
      a_eq_b <= 1'b0;
      a_lt_b <= 1'b0;
      cycles <= '0;
    end else begin
      state <= state_next;
      if (start_fire) begin
        idx   <= IDX_MSB;
        steps <= '0;
        found <= 1'b0;
        gt_w  <= 1'b0;
        lt_w  <= 1'b0;
      end else if (step_go) begin
        steps <= steps_inc;
        found <= found_next;
        gt_w  <= gt_next;
        lt_w  <= lt_next;
        if (last_step) begin
          // Published result holds through and after DONE until the next walk completes.
          a_gt_b <= gt_next;
          a_lt_b <= lt_next;
          a_eq_b <= ~found_next;
          cycles <= steps_inc;
        end else begin
          idx <= idx - IW'(1);
        end
      end
    end
  end

endmodule
